// File: rtl/led_blink_pkg.sv
// Shared encodings for the multi-channel LED pattern generator.
package led_blink_pkg;

  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_ON      = 2'd1;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_ONESHOT = 2'd3;

  typedef enum logic {
    PHASE_ON  = 1'b0,
    PHASE_OFF = 1'b1
  } phase_e;

endpackage

// File: rtl/led_blink_chan.sv
// One LED channel: config registers, duration counter, phase, led and done pulse.
module led_blink_chan
  import led_blink_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned DEF_ON  = 50000000,
  parameter int unsigned DEF_OFF = 25000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             wr_en,
  input  logic [1:0]       wr_mode,
  input  logic [CNT_W-1:0] wr_on,
  input  logic [CNT_W-1:0] wr_off,
  output logic             led,
  output logic             done
);

  logic [1:0]       mode_q, mode_d;
  logic [CNT_W-1:0] on_q, on_d;
  logic [CNT_W-1:0] off_q, off_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  phase_e           phase_q, phase_d;
  logic             led_q, led_d;
  logic             done_q, done_d;

  // Terminal counts; a zero duration behaves as one tick.
  logic [CNT_W-1:0] on_last_c, off_last_c;
  assign on_last_c  = (on_q  == '0) ? '0 : on_q  - CNT_W'(1);
  assign off_last_c = (off_q == '0) ? '0 : off_q - CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= MODE_OFF;
      on_q    <= CNT_W'(DEF_ON);
      off_q   <= CNT_W'(DEF_OFF);
      cnt_q   <= '0;
      phase_q <= PHASE_ON;
      led_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      on_q    <= on_d;
      off_q   <= off_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

  // A write always wins over a phase end in the same cycle.
  always_comb begin
    mode_d  = mode_q;
    on_d    = on_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    led_d   = led_q;
    done_d  = 1'b0;
    if (wr_en) begin
      mode_d  = wr_mode;
      on_d    = wr_on;
      off_d   = wr_off;
      cnt_d   = '0;
      phase_d = PHASE_ON;
      led_d   = (wr_mode != MODE_OFF);
    end else if (tick) begin
      case (mode_q)
        MODE_OFF: led_d = 1'b0;
        MODE_ON:  led_d = 1'b1;
        MODE_BLINK: begin
          if (phase_q == PHASE_ON) begin
            if (cnt_q == on_last_c) begin
              led_d   = 1'b0;
              phase_d = PHASE_OFF;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            if (cnt_q == off_last_c) begin
              led_d   = 1'b1;
              phase_d = PHASE_ON;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          if (phase_q == PHASE_ON) begin
            if (cnt_q == on_last_c) begin
              led_d  = 1'b0;
              mode_d = MODE_OFF;
              cnt_d  = '0;
              done_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

  assign led  = led_q;
  assign done = done_q;

endmodule

// File: rtl/led_blink_multi.sv
// N-channel LED pattern generator: shared tick prescaler, config write decode, channels.
module led_blink_multi
  import led_blink_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned CH_W     = 3,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned DEF_ON   = 50000000,
  parameter int unsigned DEF_OFF  = 25000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_on,
  input  logic [CNT_W-1:0] cfg_off,
  output logic             cfg_err,
  output logic [N_CH-1:0]  led,
  output logic [N_CH-1:0]  done
);

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PRE_W-1:0] pre_q, pre_d;
  logic             cfg_ready_q;
  logic             cfg_err_q, cfg_err_d;
  logic             tick_c;
  logic             accept_c;
  logic             in_range_c;

  assign tick_c     = en && (pre_q == PRE_W'(PRESCALE - 1));
  assign accept_c   = cfg_valid && cfg_ready_q;
  assign in_range_c = (32'(cfg_ch) < 32'(N_CH));

  // Prescaler freezes with en low so a paused duration resumes exactly.
  always_comb begin
    pre_d     = pre_q;
    cfg_err_d = accept_c && !in_range_c;
    if (tick_c) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q       <= '0;
      cfg_ready_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      pre_q       <= pre_d;
      cfg_ready_q <= 1'b1;
      cfg_err_q   <= cfg_err_d;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    logic wr_en_c;
    assign wr_en_c = accept_c && (cfg_ch == CH_W'(i));

    led_blink_chan #(
      .CNT_W  (CNT_W),
      .DEF_ON (DEF_ON),
      .DEF_OFF(DEF_OFF)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick_c),
      .wr_en  (wr_en_c),
      .wr_mode(cfg_mode),
      .wr_on  (cfg_on),
      .wr_off (cfg_off),
      .led    (led[i]),
      .done   (done[i])
    );
  end

  assign cfg_ready = cfg_ready_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_led_blink_multi.sv
// Scoreboard bench for led_blink_multi: PRESCALE=1 instance (A) and PRESCALE=4 instance (B).
module tb_led_blink_multi;

  localparam logic [1:0] M_OFF = 2'd0, M_ON = 2'd1, M_BLINK = 2'd2, M_ONE = 2'd3;

  typedef struct packed {
    logic [3:0] led;
    logic [3:0] done;
    logic       err;
    logic       rdy;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_a, reset_b, en, cfg_valid;
  logic [2:0] cfg_ch;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_on, cfg_off;
  logic       rdy_a, err_a, rdy_b, err_b;
  logic [3:0] led_a, done_a, led_b, done_b;

  int errors = 0;
  int checks = 0;
  exp_t qa[$];
  exp_t qb[$];

  always #5 clk = ~clk;

  led_blink_multi #(.N_CH(4), .CH_W(3), .CNT_W(8), .PRESCALE(1), .DEF_ON(50), .DEF_OFF(25)) u_a (
    .clk(clk), .reset(reset_a), .en(en), .cfg_valid(cfg_valid), .cfg_ready(rdy_a),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_on(cfg_on), .cfg_off(cfg_off),
    .cfg_err(err_a), .led(led_a), .done(done_a)
  );

  led_blink_multi #(.N_CH(4), .CH_W(3), .CNT_W(8), .PRESCALE(4), .DEF_ON(50), .DEF_OFF(25)) u_b (
    .clk(clk), .reset(reset_b), .en(en), .cfg_valid(cfg_valid), .cfg_ready(rdy_b),
    .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_on(cfg_on), .cfg_off(cfg_off),
    .cfg_err(err_b), .led(led_b), .done(done_b)
  );

  // Monitor: every cycle's outputs are compared against the next queued expectation.
  initial begin
    exp_t got, want;
    int   cyc;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (qa.size() != 0) begin
        want = qa.pop_front();
        got  = {led_a, done_a, err_a, rdy_a};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL dutA cyc %0d: got led=%b done=%b err=%b rdy=%b, want led=%b done=%b err=%b rdy=%b",
                   cyc, got.led, got.done, got.err, got.rdy, want.led, want.done, want.err, want.rdy);
        end
      end
      if (qb.size() != 0) begin
        want = qb.pop_front();
        got  = {led_b, done_b, err_b, rdy_b};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL dutB cyc %0d: got led=%b done=%b err=%b rdy=%b, want led=%b done=%b err=%b rdy=%b",
                   cyc, got.led, got.done, got.err, got.rdy, want.led, want.done, want.err, want.rdy);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic exp_t e(input logic [3:0] l, input logic [3:0] d, input logic er, input logic rd);
    return {l, d, er, rd};
  endfunction

  task automatic step(input bit ca, input exp_t ea, input bit cb, input exp_t eb);
    if (ca) qa.push_back(ea);
    if (cb) qb.push_back(eb);
    @(posedge clk);
    #2;
  endtask

  task automatic sa(input logic [3:0] l, input logic [3:0] d, input logic er);
    step(1'b1, e(l, d, er, 1'b1), 1'b0, '0);
  endtask

  task automatic sb(input logic [3:0] l, input logic rd);
    step(1'b0, '0, 1'b1, e(l, 4'b0000, 1'b0, rd));
  endtask

  task automatic wr(input logic [2:0] ch, input logic [1:0] m, input logic [7:0] on, input logic [7:0] off);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_mode  = m;
    cfg_on    = on;
    cfg_off   = off;
  endtask

  initial begin
    logic [10:0] pat2;
    pat2      = 11'b10011100111;
    reset_a   = 1'b1;
    reset_b   = 1'b1;
    en        = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_mode  = M_OFF;
    cfg_on    = '0;
    cfg_off   = '0;

    // Reset held 3 cycles, then ready on the first free edge
    repeat (3) step(1'b1, e(4'b0000, 4'b0000, 1'b0, 1'b0), 1'b0, '0);
    reset_a = 1'b0;
    sa(4'b0000, 4'b0000, 1'b0);
    sa(4'b0000, 4'b0000, 1'b0);

    // ch1 BLINK on=3 off=2: period 5, zero write-to-LED latency
    wr(3'd1, M_BLINK, 8'd3, 8'd2);
    sa(4'b0010, 4'b0000, 1'b0);
    cfg_valid = 1'b0;
    for (int i = 1; i <= 10; i++) sa(pat2[i] ? 4'b0010 : 4'b0000, 4'b0000, 1'b0);
    wr(3'd1, M_OFF, 8'd0, 8'd0);
    sa(4'b0000, 4'b0000, 1'b0);
    cfg_valid = 1'b0;

    // ch2 ONESHOT on=4: 4 cycles high, done as it falls, stays low
    wr(3'd2, M_ONE, 8'd4, 8'd0);
    sa(4'b0100, 4'b0000, 1'b0);
    cfg_valid = 1'b0;
    repeat (3) sa(4'b0100, 4'b0000, 1'b0);
    sa(4'b0000, 4'b0100, 1'b0);
    repeat (4) sa(4'b0000, 4'b0000, 1'b0);

    // Rewrite in the cycle a ONESHOT would end: no done, restart with on=2
    wr(3'd2, M_ONE, 8'd1, 8'd0);
    sa(4'b0100, 4'b0000, 1'b0);
    wr(3'd2, M_ONE, 8'd2, 8'd0);
    sa(4'b0100, 4'b0000, 1'b0);
    cfg_valid = 1'b0;
    sa(4'b0100, 4'b0000, 1'b0);
    sa(4'b0000, 4'b0100, 1'b0);
    sa(4'b0000, 4'b0000, 1'b0);

    // Out-of-range channels 5 and 4 flag cfg_err; ch3 is the last valid one
    wr(3'd5, M_BLINK, 8'd1, 8'd1);
    sa(4'b0000, 4'b0000, 1'b1);
    cfg_valid = 1'b0;
    sa(4'b0000, 4'b0000, 1'b0);
    wr(3'd4, M_ON, 8'd1, 8'd1);
    sa(4'b0000, 4'b0000, 1'b1);
    wr(3'd3, M_ON, 8'd1, 8'd1);
    sa(4'b1000, 4'b0000, 1'b0);
    wr(3'd3, M_OFF, 8'd1, 8'd1);
    sa(4'b0000, 4'b0000, 1'b0);
    cfg_valid = 1'b0;

    // ch1 BLINK on=6 paused for 10 cycles after 2 on-cycles; write during pause
    wr(3'd1, M_BLINK, 8'd6, 8'd3);
    sa(4'b0010, 4'b0000, 1'b0);
    cfg_valid = 1'b0;
    repeat (2) sa(4'b0010, 4'b0000, 1'b0);
    en = 1'b0;
    cfg_ch   = 3'd3;
    cfg_mode = M_ON;
    for (int k = 0; k < 10; k++) begin
      cfg_valid = (k == 4);
      sa((k >= 4) ? 4'b1010 : 4'b0010, 4'b0000, 1'b0);
    end
    cfg_valid = 1'b0;
    en = 1'b1;
    repeat (3) sa(4'b1010, 4'b0000, 1'b0);
    sa(4'b1000, 4'b0000, 1'b0);
    wr(3'd3, M_OFF, 8'd0, 8'd0);
    sa(4'b0000, 4'b0000, 1'b0);
    wr(3'd1, M_OFF, 8'd0, 8'd0);
    sa(4'b0000, 4'b0000, 1'b0);
    cfg_valid = 1'b0;

    // PRESCALE=4 instance: ch0 BLINK on=0 off=1 toggles every 4 cycles, then reset
    reset_b = 1'b0;
    sb(4'b0000, 1'b1);
    wr(3'd0, M_BLINK, 8'd0, 8'd1);
    sb(4'b0001, 1'b1);
    cfg_valid = 1'b0;
    for (int k = 2; k <= 16; k++) sb(((((k + 1) >> 2) % 2) == 0) ? 4'b0001 : 4'b0000, 1'b1);
    reset_b = 1'b1;
    sb(4'b0000, 1'b0);
    reset_b = 1'b0;
    sb(4'b0000, 1'b1);

    @(posedge clk);
    #5;
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d unchecked entries, want 0/0", qa.size(), qb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
